// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm time register: FSM state codes,
// time-field limits and the ring/snooze timer width.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } alarm_state_e;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned TIMER_W  = 9;

endpackage

// File: rtl/alarm_field_counter.sv
// One alarm time field: increments by one per pulse and wraps from
// MAX_VAL back to 0. No carry out; each field is edited independently.
module alarm_field_counter #(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned MAX_VAL = 59,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: hold, increment, or wrap at the field maximum
    always_comb begin
        value_d = value_q;
        if (inc) begin
            value_d = (value_q == WIDTH'(MAX_VAL)) ? '0 : value_q + WIDTH'(1);
        end
    end

    // Field register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) value_q <= WIDTH'(RST_VAL);
        else        value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/alarm_time_register.sv
// Alarm time storage, time match and ring/snooze/timeout FSM.
// Optional feature: define ALARM_SNOOZE_EN to enable the SNOOZE state;
// without it the snooze input is ignored and SNOOZE_SEC is unused.
module alarm_time_register
    import alarm_pkg::*;
#(
    parameter int unsigned RING_TIMEOUT = 60,
    parameter int unsigned SNOOZE_SEC   = 300,
    parameter int unsigned RST_HOUR     = 6,
    parameter int unsigned RST_MIN      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upsec,
    input  logic       upmin,
    input  logic       uphour,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic       dismiss,
    input  logic       snooze,
    output logic [5:0] alm_sec,
    output logic [5:0] alm_min,
    output logic [4:0] alm_hour,
    output logic       ringing,
    output logic [1:0] alm_state
);

    alarm_state_e       state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               ringing_q, ringing_d;
    logic               tick_q;
    logic               match;
    logic               trigger;

    alarm_field_counter #(.WIDTH(6), .MAX_VAL(SEC_MAX), .RST_VAL(0)) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (upsec),
        .value (alm_sec)
    );

    alarm_field_counter #(.WIDTH(6), .MAX_VAL(MIN_MAX), .RST_VAL(RST_MIN)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (upmin),
        .value (alm_min)
    );

    alarm_field_counter #(.WIDTH(5), .MAX_VAL(HOUR_MAX), .RST_VAL(RST_HOUR)) u_hour (
        .clk   (clk),
        .reset (reset),
        .inc   (uphour),
        .value (alm_hour)
    );

    // tick_q lines up with the freshly updated cur_* so each second is compared once
    assign match   = (cur_sec == alm_sec) && (cur_min == alm_min) && (cur_hour == alm_hour);
    assign trigger = tick_q & match;

`ifndef ALARM_SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = ^{snooze, TIMER_W'(SNOOZE_SEC)};
`endif

    // Next-state and timer logic; alarm_en low overrides everything
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!alarm_en) begin
            state_d = ST_DISARMED;
        end else begin
            unique case (state_q)
                ST_DISARMED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (trigger) begin
                        state_d = ST_RINGING;
                        timer_d = TIMER_W'(RING_TIMEOUT);
                    end
                end
                ST_RINGING: begin
                    if (dismiss) begin
                        state_d = ST_ARMED;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_d = ST_SNOOZE;
                        timer_d = TIMER_W'(SNOOZE_SEC);
`endif
                    end else if (tick_1hz) begin
                        if (timer_q == TIMER_W'(1)) state_d = ST_ARMED;
                        else                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                    if (dismiss) begin
                        state_d = ST_ARMED;
                    end else if (tick_1hz) begin
                        if (timer_q == TIMER_W'(1)) begin
                            state_d = ST_RINGING;
                            timer_d = TIMER_W'(RING_TIMEOUT);
                        end else begin
                            timer_d = timer_q - TIMER_W'(1);
                        end
                    end
`else
                    // Unreachable in this build; recover to a legal state
                    state_d = ST_ARMED;
`endif
                end
                default: state_d = ST_DISARMED;
            endcase
        end
        ringing_d = (state_d == ST_RINGING);
    end

    // FSM, timer, registered ringing output and delayed tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_DISARMED;
            timer_q   <= '0;
            ringing_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ringing_q <= ringing_d;
            tick_q    <= tick_1hz;
        end
    end

    assign ringing   = ringing_q;
    assign alm_state = state_q;

endmodule

// File: tb/tb_alarm_time_register.sv
// Directed bench for alarm_time_register (RING_TIMEOUT=3, SNOOZE_SEC=2).
// Expectations follow ALARM_SNOOZE_EN when the macro is defined.
module tb_alarm_time_register;

    logic       clk = 1'b0;
    logic       reset;
    logic       upsec, upmin, uphour;
    logic [5:0] cur_sec, cur_min;
    logic [4:0] cur_hour;
    logic       tick_1hz, alarm_en, dismiss, snooze;
    logic [5:0] alm_sec, alm_min;
    logic [4:0] alm_hour;
    logic       ringing;
    logic [1:0] alm_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alarm_time_register #(
        .RING_TIMEOUT (3),
        .SNOOZE_SEC   (2),
        .RST_HOUR     (6),
        .RST_MIN      (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .upsec     (upsec),
        .upmin     (upmin),
        .uphour    (uphour),
        .cur_sec   (cur_sec),
        .cur_min   (cur_min),
        .cur_hour  (cur_hour),
        .tick_1hz  (tick_1hz),
        .alarm_en  (alarm_en),
        .dismiss   (dismiss),
        .snooze    (snooze),
        .alm_sec   (alm_sec),
        .alm_min   (alm_min),
        .alm_hour  (alm_hour),
        .ringing   (ringing),
        .alm_state (alm_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mask bit0=sec, bit1=min, bit2=hour
    task automatic pulse_edit(input logic [2:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {uphour, upmin, upsec} = m;
            @(posedge clk);
            #1;
            {uphour, upmin, upsec} = 3'b000;
        end
    endtask

    // Timekeeper model: cur_* change on the same edge that samples tick_1hz
    task automatic do_tick(input int h, input int mn, input int s);
        @(negedge clk);
        tick_1hz = 1'b1;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        cur_hour = 5'(h);
        cur_min  = 6'(mn);
        cur_sec  = 6'(s);
    endtask

    task automatic ctl_pulse(input logic d, input logic s);
        @(negedge clk);
        dismiss = d;
        snooze  = s;
        @(posedge clk);
        #1;
        dismiss = 1'b0;
        snooze  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        {upsec, upmin, uphour} = 3'b000;
        tick_1hz = 1'b0; alarm_en = 1'b0; dismiss = 1'b0; snooze = 1'b0;
        cur_hour = 5'd5; cur_min = 6'd59; cur_sec = 6'd59;
        #12;
        chk("rst_hour", alm_hour, 6);
        chk("rst_min", alm_min, 0);
        chk("rst_sec", alm_sec, 0);
        chk("rst_state", alm_state, 0);
        chk("rst_ringing", ringing, 0);
        @(negedge clk);
        reset = 1'b1;

        // Field edits and wrap
        pulse_edit(3'b100, 17);
        chk("hour_23", alm_hour, 23);
        pulse_edit(3'b100, 1);
        chk("hour_wrap", alm_hour, 0);
        pulse_edit(3'b100, 6);
        chk("hour_back6", alm_hour, 6);
        pulse_edit(3'b010, 59);
        chk("min_59", alm_min, 59);
        pulse_edit(3'b010, 1);
        chk("min_wrap", alm_min, 0);
        chk("min_wrap_nocarry", alm_hour, 6);
        pulse_edit(3'b111, 1);
        chk("simul_hour", alm_hour, 7);
        chk("simul_min", alm_min, 1);
        chk("simul_sec", alm_sec, 1);
        chk("edit_state", alm_state, 0);
        pulse_edit(3'b111, 23);
        pulse_edit(3'b011, 36);
        chk("restore_hour", alm_hour, 6);
        chk("restore_min", alm_min, 0);
        chk("restore_sec", alm_sec, 0);

        // Arm and ring on the 05:59:59 -> 06:00:00 tick
        @(negedge clk);
        alarm_en = 1'b1;
        step(1);
        chk("armed", alm_state, 1);
        do_tick(6, 0, 0);
        chk("ring_lat1", ringing, 0);
        step(1);
        chk("ring_lat2", ringing, 1);
        chk("ring_state", alm_state, 2);

        // Timeout after three ticks
        do_tick(6, 0, 1);
        chk("to_tick1", alm_state, 2);
        do_tick(6, 0, 2);
        chk("to_tick2", alm_state, 2);
        do_tick(6, 0, 3);
        chk("to_state", alm_state, 1);
        chk("to_ringing", ringing, 0);
        step(2);
        chk("to_stay_armed", alm_state, 1);

        // Edit creates a match mid-second: no ring
        pulse_edit(3'b001, 3);
        chk("edit_sec3", alm_sec, 3);
        step(3);
        chk("midsec_noring", ringing, 0);
        chk("midsec_state", alm_state, 1);

        // Ring again on a tick at the matching second
        do_tick(6, 0, 3);
        step(1);
        chk("ring2", ringing, 1);

        // Snooze handling
        ctl_pulse(1'b0, 1'b1);
`ifdef ALARM_SNOOZE_EN
        chk("snz_state", alm_state, 3);
        chk("snz_ringing", ringing, 0);
`else
        chk("snz_state", alm_state, 2);
        chk("snz_ringing", ringing, 1);
`endif
        do_tick(6, 0, 4);
        do_tick(6, 0, 5);
        chk("snz_after_state", alm_state, 2);
        chk("snz_after_ringing", ringing, 1);

        // Dismiss wins over snooze
        ctl_pulse(1'b1, 1'b1);
        chk("dismiss_state", alm_state, 1);
        chk("dismiss_ringing", ringing, 0);

        // Disarm
        @(negedge clk);
        alarm_en = 1'b0;
        step(1);
        chk("disarm", alm_state, 0);

        // Re-arm, ring, then asynchronous reset mid-ring
        @(negedge clk);
        alarm_en = 1'b1;
        step(1);
        chk("rearm", alm_state, 1);
        do_tick(6, 0, 3);
        step(1);
        chk("ring3", ringing, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ringing", ringing, 0);
        chk("arst_state", alm_state, 0);
        chk("arst_hour", alm_hour, 6);
        chk("arst_min", alm_min, 0);
        chk("arst_sec", alm_sec, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
